// File: rtl/vga_rx_pkg.sv
// Shared types and default geometry for the VGA frame receiver.
package vga_rx_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  // Coordinates are carried at a fixed width inside the FIFO and trimmed at the port.
  localparam int COORD_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEEK    = 2'd1,
    ST_CAPTURE = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [23:0]        rgb;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               sof;
    logic               eol;
  } pix_entry_t;

endpackage

// File: rtl/vga_rx_fifo.sv
// First-word-fall-through FIFO of pixel entries; a write into a full FIFO
// succeeds when a read happens in the same cycle.
module vga_rx_fifo
  import vga_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       wr_en,
  input  pix_entry_t wr_data,
  input  logic       rd_en,
  output pix_entry_t rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  pix_entry_t  mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        wr_ok_s;
  logic        rd_ok_s;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rd_ok_s = rd_en && !empty;
  assign wr_ok_s = wr_en && (!full || rd_ok_s);
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer update.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Storage array, cleared so the head reads as zero out of reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
    end else if (wr_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/vga_frame_rx.sv
// VGA receive port: recovers pixel position from BLANK/VS and streams active pixels.
// Optional line/frame length checking is built when VGA_RX_GEOM_CHECK_EN is defined.
module vga_frame_rx
  import vga_rx_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int FIFO_DEPTH = 16,
  parameter int X_W        = 10,
  parameter int Y_W        = 10
) (
  input  logic           clk_clk,
  input  logic           reset_reset_n,
  input  logic           vga_HS,
  input  logic           vga_VS,
  input  logic           vga_BLANK,
  input  logic [7:0]     vga_R,
  input  logic [7:0]     vga_G,
  input  logic [7:0]     vga_B,
  input  logic           enable,
  input  logic           clear_err,
  output logic [23:0]    pix_data,
  output logic [X_W-1:0] pix_x,
  output logic [Y_W-1:0] pix_y,
  output logic           pix_sof,
  output logic           pix_eol,
  output logic           pix_valid,
  input  logic           pix_ready,
  output logic           frame_done,
  output logic           overflow,
  output logic           geom_err
);

  localparam logic [X_W-1:0] H_LIM  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0] V_LIM  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] Y_MAX  = {Y_W{1'b1}};
  localparam logic [X_W-1:0] X_ZERO = {X_W{1'b0}};
  localparam logic [Y_W-1:0] Y_ZERO = {Y_W{1'b0}};
  localparam logic [X_W-1:0] X_ONE  = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE  = Y_W'(1);

  logic        hs_q, vs_q, blank_q, vs_qq, blank_qq;
  logic [23:0] rgb_q;
  logic        vs_start_s, line_end_s;

  rx_state_t      state_r, state_nx_s;
  logic [X_W-1:0] x_r, x_nx_s;
  logic [Y_W-1:0] y_r, y_nx_s;
  logic           wr_en_s, rd_en_s, done_evt_s, ovf_evt_s;
  logic           fifo_full_s, fifo_empty_s;
  logic           frame_done_r, overflow_r;
  pix_entry_t     wr_entry_s, head_s;

  logic                 unused_hs_s;
  logic [2*COORD_W-1:0] unused_coord_s;

  // Input capture plus one extra stage for edge detection.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      blank_q  <= 1'b0;
      rgb_q    <= 24'h000000;
      vs_qq    <= 1'b0;
      blank_qq <= 1'b0;
    end else begin
      hs_q     <= vga_HS;
      vs_q     <= vga_VS;
      blank_q  <= vga_BLANK;
      rgb_q    <= {vga_R, vga_G, vga_B};
      vs_qq    <= vs_q;
      blank_qq <= blank_q;
    end
  end

  assign vs_start_s = vs_qq & ~vs_q;
  assign line_end_s = blank_qq & ~blank_q;
  assign pix_valid  = ~fifo_empty_s;
  assign rd_en_s    = pix_valid & pix_ready;

  // Capture FSM: next state, position counters and FIFO write decision.
  always_comb begin
    state_nx_s = state_r;
    x_nx_s     = x_r;
    y_nx_s     = y_r;
    wr_en_s    = 1'b0;
    done_evt_s = 1'b0;
    ovf_evt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable) state_nx_s = ST_SEEK;
        else        state_nx_s = ST_IDLE;
      end
      ST_SEEK: begin
        if (!enable) begin
          state_nx_s = ST_IDLE;
        end else if (vs_start_s) begin
          x_nx_s     = X_ZERO;
          y_nx_s     = Y_ZERO;
          state_nx_s = ST_CAPTURE;
        end else begin
          state_nx_s = ST_SEEK;
        end
      end
      ST_CAPTURE: begin
        if (vs_start_s) begin
          done_evt_s = 1'b1;
          x_nx_s     = X_ZERO;
          y_nx_s     = Y_ZERO;
          if (enable) state_nx_s = ST_CAPTURE;
          else        state_nx_s = ST_IDLE;
        end else if (line_end_s) begin
          x_nx_s = X_ZERO;
          if (y_r != Y_MAX) y_nx_s = y_r + Y_ONE;
          else              y_nx_s = y_r;
        end else if (blank_q && (x_r < H_LIM)) begin
          x_nx_s = x_r + X_ONE;
          // A full FIFO that is not draining this cycle abandons the frame.
          if (y_r >= V_LIM) begin
            wr_en_s = 1'b0;
          end else if (fifo_full_s && !rd_en_s) begin
            ovf_evt_s  = 1'b1;
            state_nx_s = ST_SEEK;
          end else begin
            wr_en_s = 1'b1;
          end
        end else begin
          x_nx_s = x_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, position and status flag registers.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_r      <= ST_IDLE;
      x_r          <= X_ZERO;
      y_r          <= Y_ZERO;
      frame_done_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      x_r          <= x_nx_s;
      y_r          <= y_nx_s;
      frame_done_r <= done_evt_s;
      if (ovf_evt_s)      overflow_r <= 1'b1;
      else if (clear_err) overflow_r <= 1'b0;
    end
  end

`ifdef VGA_RX_GEOM_CHECK_EN
  logic geom_evt_s;
  logic geom_err_r;

  // Line/frame length and out-of-range checks while capturing.
  always_comb begin
    geom_evt_s = 1'b0;
    if (state_r == ST_CAPTURE) begin
      if (vs_start_s)      geom_evt_s = (y_r != V_LIM) || blank_q;
      else if (line_end_s) geom_evt_s = (x_r != H_LIM);
      else if (blank_q)    geom_evt_s = (x_r >= H_LIM) || (y_r >= V_LIM);
      else                 geom_evt_s = 1'b0;
    end else begin
      geom_evt_s = 1'b0;
    end
  end

  // Sticky geometry error; a new event beats a same-cycle clear.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n)   geom_err_r <= 1'b0;
    else if (geom_evt_s)  geom_err_r <= 1'b1;
    else if (clear_err)   geom_err_r <= 1'b0;
  end

  assign geom_err = geom_err_r;
`else
  assign geom_err = 1'b0;
`endif

  assign wr_entry_s.rgb = rgb_q;
  assign wr_entry_s.x   = COORD_W'(x_r);
  assign wr_entry_s.y   = COORD_W'(y_r);
  assign wr_entry_s.sof = (x_r == X_ZERO) && (y_r == Y_ZERO);
  assign wr_entry_s.eol = (x_r == H_LAST);

  vga_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .wr_en        (wr_en_s),
    .wr_data      (wr_entry_s),
    .rd_en        (rd_en_s),
    .rd_data      (head_s),
    .full         (fifo_full_s),
    .empty        (fifo_empty_s)
  );

  assign pix_data   = head_s.rgb;
  assign pix_x      = head_s.x[X_W-1:0];
  assign pix_y      = head_s.y[Y_W-1:0];
  assign pix_sof    = head_s.sof;
  assign pix_eol    = head_s.eol;
  assign frame_done = frame_done_r;
  assign overflow   = overflow_r;

  assign unused_hs_s    = hs_q;
  assign unused_coord_s = {head_s.x, head_s.y};

endmodule

// File: tb/tb_vga_frame_rx.sv
// Directed bench for vga_frame_rx on a 4x3 geometry with a 4-entry FIFO.
module tb_vga_frame_rx;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int D  = 4;
  localparam int XW = 10;
  localparam int YW = 10;
`ifdef VGA_RX_GEOM_CHECK_EN
  localparam logic GEOM_ON = 1'b1;
`else
  localparam logic GEOM_ON = 1'b0;
`endif

  logic          clk_clk = 1'b0;
  logic          reset_reset_n = 1'b0;
  logic          vga_HS = 1'b1, vga_VS = 1'b1, vga_BLANK = 1'b0;
  logic [7:0]    vga_R = 8'h00, vga_G = 8'h00, vga_B = 8'h00;
  logic          enable = 1'b0, clear_err = 1'b0, pix_ready = 1'b1;
  logic [23:0]   pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_sof, pix_eol, pix_valid, frame_done, overflow, geom_err;

  int checks_n = 0;
  int fails_n  = 0;
  int fd_cnt   = 0;
  int clr_x    = -1;
  int clr_y    = -1;
  logic [45:0] exp_q [$];

  vga_frame_rx #(
    .H_ACTIVE(H), .V_ACTIVE(V), .FIFO_DEPTH(D), .X_W(XW), .Y_W(YW)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .vga_HS(vga_HS), .vga_VS(vga_VS), .vga_BLANK(vga_BLANK),
    .vga_R(vga_R), .vga_G(vga_G), .vga_B(vga_B),
    .enable(enable), .clear_err(clear_err),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .frame_done(frame_done),
    .overflow(overflow), .geom_err(geom_err)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_n++;
    if (got !== exp) begin
      fails_n++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_px(input int x, input int y);
    exp_q.push_back({8'(y), 8'(x), 8'h00, 10'(x), 10'(y), (x == 0 && y == 0), (x == H-1)});
  endtask

  task automatic push_frame();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) push_px(x, y);
  endtask

  task automatic drive(input logic vs, input logic bl, input logic [7:0] r, input logic [7:0] g);
    vga_VS    = vs;
    vga_HS    = bl;
    vga_BLANK = bl;
    vga_R     = r;
    vga_G     = g;
    vga_B     = 8'h00;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic vsync();
    repeat (2) drive(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) drive(1'b1, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic line(input int npix, input int yv);
    for (int i = 0; i < npix; i++) begin
      clear_err = (i == clr_x && yv == clr_y);
      drive(1'b1, 1'b1, 8'(yv), 8'(i));
    end
    clear_err = 1'b0;
    repeat (3) drive(1'b1, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic frame(input int long_y);
    for (int y = 0; y < V; y++) line((y == long_y) ? H + 1 : H, y);
    vsync();
  endtask

  // Output monitor: every transfer is compared against the expected queue.
  always @(negedge clk_clk) begin
    logic [45:0] exp_v;
    if (frame_done === 1'b1) fd_cnt++;
    if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : {46{1'b1}};
      check_eq("pix", {pix_data, pix_x, pix_y, pix_sof, pix_eol}, exp_v);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_clk);
    #1;
    check_eq("rst_valid", pix_valid, 0);
    check_eq("rst_done", frame_done, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_geom", geom_err, 0);
    check_eq("rst_data", pix_data, 0);
    check_eq("rst_xy", {pix_x, pix_y, pix_sof, pix_eol}, 0);

    reset_reset_n = 1'b1;
    enable        = 1'b1;
    repeat (2) drive(1'b1, 1'b0, 8'h00, 8'h00);
    vsync();

    // Frame A: normal raster.
    push_frame();
    frame(-1);
    check_eq("a_done", fd_cnt, 1);
    check_eq("a_ovf", overflow, 0);
    check_eq("a_geom", geom_err, 0);
    check_eq("a_drained", exp_q.size(), 0);

    // Frame B: stalled consumer, clear_err coincides with the overflow event.
    pix_ready = 1'b0;
    clr_x = 1;
    clr_y = 1;
    for (int x = 0; x < H; x++) push_px(x, 0);
    frame(-1);
    clr_x = -1;
    clr_y = -1;
    check_eq("b_stall_valid", pix_valid, 1);
    check_eq("b_stall_sof", {pix_sof, pix_x, pix_y}, {1'b1, 10'd0, 10'd0});
    check_eq("b_ovf_wins", overflow, 1);
    check_eq("b_no_done", fd_cnt, 1);
    pix_ready = 1'b1;
    repeat (6) drive(1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("b_drained", exp_q.size(), 0);
    clear_err = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    clear_err = 1'b0;
    check_eq("b_ovf_clr", overflow, 0);

    // Frame C: complete after the overflowed one.
    push_frame();
    frame(-1);
    check_eq("c_done", fd_cnt, 2);
    check_eq("c_drained", exp_q.size(), 0);

    // Frame D: line 1 carries one extra pixel.
    push_frame();
    frame(1);
    check_eq("d_done", fd_cnt, 3);
    check_eq("d_drained", exp_q.size(), 0);
    check_eq("d_geom", geom_err, GEOM_ON);
    clear_err = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    clear_err = 1'b0;
    check_eq("d_geom_clr", geom_err, 0);

    // Frame E: enable drops mid-frame, frame still completes.
    push_frame();
    line(H, 0);
    enable = 1'b0;
    line(H, 1);
    line(H, 2);
    vsync();
    check_eq("e_done", fd_cnt, 4);
    check_eq("e_drained", exp_q.size(), 0);

    // Frame F: disabled, nothing emitted.
    frame(-1);
    check_eq("f_no_done", fd_cnt, 4);
    check_eq("f_no_valid", pix_valid, 0);

    // Frame G: enable rises mid-frame, output waits for the next VS.
    line(H, 0);
    enable = 1'b1;
    line(H, 1);
    line(H, 2);
    check_eq("g_no_valid", pix_valid, 0);
    vsync();
    check_eq("g_no_done", fd_cnt, 4);

    // Frame H: first captured frame after re-enable.
    push_frame();
    frame(-1);
    check_eq("h_done", fd_cnt, 5);
    check_eq("h_drained", exp_q.size(), 0);

    // Reset mid-line with queued entries and a sticky flag set.
    pix_ready = 1'b0;
    line(H, 0);
    drive(1'b1, 1'b1, 8'h01, 8'h00);
    drive(1'b1, 1'b1, 8'h01, 8'h01);
    check_eq("i_pre_ovf", overflow, 1);
    check_eq("i_pre_valid", pix_valid, 1);
    reset_reset_n = 1'b0;
    drive(1'b1, 1'b1, 8'h01, 8'h02);
    reset_reset_n = 1'b1;
    check_eq("i_rst_valid", pix_valid, 0);
    check_eq("i_rst_flags", {overflow, geom_err, frame_done}, 0);
    drive(1'b1, 1'b1, 8'h01, 8'h03);
    repeat (3) drive(1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("i_empty", pix_valid, 0);
    pix_ready = 1'b1;
    vsync();

    // Frame J: capture restarts after reset.
    push_frame();
    frame(-1);
    check_eq("j_done", fd_cnt, 6);
    check_eq("j_drained", exp_q.size(), 0);
    check_eq("j_flags", {overflow, geom_err}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fails_n);
    $finish;
  end

endmodule
